// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one low column at a time, debounces press and
// release on the captured row/column, and reports each accepted key with a one-cycle strobe.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         row_meta_q, rs_q;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;

    logic watched_low;
    logic scan_done;
    logic deb_done;

    assign watched_low = ~rs_q[row_idx_q];
    assign scan_done   = (dwell_q == DWELL_LAST);
    assign deb_done    = (deb_q == DEB_LAST);

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

    // Lowest-index low row wins when several rows are pulled low together.
    function automatic logic [1:0] first_low(input logic [3:0] r);
        if (!r[0]) return 2'd0;
        if (!r[1]) return 2'd1;
        if (!r[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_SCAN;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: begin
                if (scan_done && (rs_q != 4'hF)) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!watched_low)  state_d = ST_SCAN;
                else if (deb_done) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!watched_low) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (watched_low)   state_d = ST_HELD;
                else if (deb_done) state_d = ST_SCAN;
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Counter, capture and output next values
    always_comb begin
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        case (state_q)
            ST_SCAN: begin
                dwell_d = dwell_q + DWELL_W'(1);
                if (scan_done) begin
                    dwell_d = '0;
                    if (rs_q == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = first_low(rs_q);
                        deb_d     = '0;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (!watched_low) begin
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                end else if (deb_done) begin
                    key_code_d  = key_map(row_idx_q, col_idx_q);
                    key_valid_d = 1'b1;
                    key_down_d  = 1'b1;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            ST_HELD: begin
                if (!watched_low) deb_d = '0;
            end
            ST_RELEASE: begin
                if (!watched_low) begin
                    if (deb_done) begin
                        key_down_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                        dwell_d    = '0;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
            end
            default: ;
        endcase
        col_d = ~(4'b0001 << col_idx_d);
    end

    // Row synchronizer and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q  <= 4'hF;
            rs_q        <= 4'hF;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            row_meta_q  <= row;
            rs_q        <= row_meta_q;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

endmodule
